logic_unit_pipe: RTL and testbench

- Next-generation ALU logic unit: eight bitwise operations, parametrised operand width and pipeline depth.
- Elastic valid/ready pipeline with backpressure, a caller tag carried through, zero/parity flags, and a completed-operation counter.
- Sits between the ALU operand-issue stage and the ALU result mux.
- Replaces the combinational logic unit wherever timing needs registered results.

---
 rtl/logic_unit_pipe.sv | 127 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined eight-op bitwise logic unit with an elastic valid/ready pipeline,
// a carried tag, zero/parity flags and a count of consumed results.
module logic_unit_pipe #(
    parameter int OPERAND_WIDTH = 32,
    parameter int STAGES        = 2,
    parameter int TAG_WIDTH     = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [OPERAND_WIDTH-1:0] lhs,
    input  logic [OPERAND_WIDTH-1:0] rhs,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] res,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     zero,
    output logic                     parity,
    output logic [COUNT_WIDTH-1:0]   ops_done
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]        r_valid;
    logic [STAGES-1:0]        w_adv;
    logic [OPERAND_WIDTH-1:0] r_res [STAGES];
    logic [TAG_WIDTH-1:0]     r_tag [STAGES];
    logic [STAGES-1:0]        r_zero;
    logic [STAGES-1:0]        r_parity;
    logic [COUNT_WIDTH-1:0]   r_ops_done;
    logic [OPERAND_WIDTH-1:0] w_res;
    logic                     w_zero;
    logic                     w_parity;
    logic                     w_load0;

    always_comb begin
        w_res = lhs & rhs;
        case (op)
            3'b000: w_res = lhs & rhs;
            3'b001: w_res = lhs | rhs;
            3'b010: w_res = lhs ^ rhs;
            3'b011: w_res = ~(lhs & rhs);
            3'b100: w_res = ~(lhs | rhs);
            3'b101: w_res = ~(lhs ^ rhs);
            3'b110: w_res = lhs & ~rhs;
            3'b111: w_res = lhs | ~rhs;
        endcase
    end

    assign w_zero   = ~|w_res;
    assign w_parity = ^w_res;

    // A stage may advance if any stage at or after it is empty, or the consumer takes the head.
    always_comb begin : adv_chain
        logic v_bubble;
        v_bubble = 1'b0;
        w_adv    = '0;
        for (int i = LAST; i >= 0; i--) begin
            v_bubble = v_bubble | ~r_valid[i];
            w_adv[i] = v_bubble | out_ready;
        end
    end

    assign in_ready = w_adv[0] & ~flush;
    assign w_load0  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (w_adv[0]) r_valid[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i]) r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Data registers only load when a valid entry moves in, so a stalled head stays frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_res[i] <= '0;
                r_tag[i] <= '0;
            end
            r_zero   <= '0;
            r_parity <= '0;
        end else begin
            if (w_load0) begin
                r_res[0]    <= w_res;
                r_tag[0]    <= in_tag;
                r_zero[0]   <= w_zero;
                r_parity[0] <= w_parity;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i] && r_valid[i-1]) begin
                    r_res[i]    <= r_res[i-1];
                    r_tag[i]    <= r_tag[i-1];
                    r_zero[i]   <= r_zero[i-1];
                    r_parity[i] <= r_parity[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ops_done <= '0;
        end else if (r_valid[LAST] && out_ready) begin
            r_ops_done <= r_ops_done + COUNT_WIDTH'(1);
        end
    end

    assign out_valid = r_valid[LAST];
    assign res       = r_res[LAST];
    assign out_tag   = r_tag[LAST];
    assign zero      = r_zero[LAST];
    assign parity    = r_parity[LAST];
    assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: a queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_logic_unit_pipe;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int T   = 4;
    localparam int CW  = 16;
    localparam int CW2 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    op = '0;
    logic [W-1:0]  lhs = '0;
    logic [W-1:0]  rhs = '0;
    logic [T-1:0]  in_tag = '0;

    logic          in_ready, out_valid, zero, parity;
    logic [W-1:0]  res;
    logic [T-1:0]  out_tag;
    logic [CW-1:0] ops_done;

    logic           in_ready_b, out_valid_b, zero_b, parity_b;
    logic [W-1:0]   res_b;
    logic [T-1:0]   out_tag_b;
    logic [CW2-1:0] ops_done_b;

    logic_unit_pipe #(.OPERAND_WIDTH(W), .STAGES(S), .TAG_WIDTH(T), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .lhs(lhs), .rhs(rhs), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .out_tag(out_tag), .zero(zero),
        .parity(parity), .ops_done(ops_done)
    );

    logic_unit_pipe #(.OPERAND_WIDTH(W), .STAGES(S), .TAG_WIDTH(T), .COUNT_WIDTH(CW2)) dutSmall (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .op(op),
        .lhs(lhs), .rhs(rhs), .in_tag(in_tag), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .res(res_b), .out_tag(out_tag_b), .zero(zero_b),
        .parity(parity_b), .ops_done(ops_done_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [T-1:0] tag;
        int           earliest;
        int           acceptCyc;
    } item_t;

    typedef struct {
        logic [W-1:0] res;
        logic [T-1:0] tag;
        logic         zero;
        logic         parity;
        int           acceptCyc;
        int           popCyc;
    } pop_t;

    item_t         q[$];
    pop_t          popLog[$];
    int            cycle = 0;
    int            acceptCount = 0;
    int            popCount = 0;
    logic [CW-1:0] modelDone = '0;
    int            asserts = 0;
    int            failures = 0;

    item_t newItem;
    item_t headItem;
    pop_t  logEntry;
    logic  expReady;
    logic  expValid;

    function automatic logic [W-1:0] refOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return a | ~b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        asserts++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic timeoutFail(input string name);
        asserts++;
        failures++;
        $display("[TB] FAIL %s: timed out, got busy, expected idle", name);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [T-1:0] t,
                                 input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        op        = o;
        lhs       = a;
        rhs       = b;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic drain();
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            #3;
            if (q.size() == 0) return;
            @(negedge clk);
        end
        timeoutFail("drain");
    endtask

    // Reference model: every accepted op becomes visible STAGES cycles after acceptance
    // and leaves in order; the unit is ready whenever it holds fewer than STAGES ops.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                checkOutput("reset out_valid", out_valid, 0);
                checkOutput("reset res", res, 0);
                checkOutput("reset ops_done", ops_done, 0);
                checkOutput("reset ops_done small", ops_done_b, 0);
                q.delete();
                modelDone = '0;
            end else begin
                expReady = !flush && (q.size() < S || out_ready);
                expValid = q.size() > 0 && cycle >= q[0].earliest;
                checkOutput("in_ready", in_ready, expReady);
                checkOutput("in_ready small", in_ready_b, expReady);
                checkOutput("out_valid", out_valid, expValid);
                checkOutput("out_valid small", out_valid_b, expValid);
                if (expValid) begin
                    headItem = q[0];
                    checkOutput("res", res, headItem.res);
                    checkOutput("out_tag", out_tag, headItem.tag);
                    checkOutput("zero", zero, headItem.res == 0);
                    checkOutput("parity", parity, ($countones(headItem.res) % 2) == 1);
                end
                checkOutput("ops_done", ops_done, modelDone);
                checkOutput("ops_done small", ops_done_b, modelDone[CW2-1:0]);
                if (expValid && out_ready) begin
                    headItem = q.pop_front();
                    logEntry.res       = res;
                    logEntry.tag       = out_tag;
                    logEntry.zero      = zero;
                    logEntry.parity    = parity;
                    logEntry.acceptCyc = headItem.acceptCyc;
                    logEntry.popCyc    = cycle;
                    popLog.push_back(logEntry);
                    popCount++;
                    modelDone = modelDone + 1'b1;
                end
                if (expReady && in_valid) begin
                    newItem.res       = refOp(op, lhs, rhs);
                    newItem.tag       = in_tag;
                    newItem.earliest  = cycle + S;
                    newItem.acceptCyc = cycle;
                    q.push_back(newItem);
                    acceptCount++;
                end
                if (flush) q.delete();
                cycle++;
            end
        end
    end

    logic [W-1:0] exp1 [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF3};
    int base;
    int a0;
    int savedPops;
    int guard;
    logic [CW-1:0] savedDone;

    initial begin
        repeat (2) @(negedge clk);
        #3;
        checkOutput("t0 out_valid in reset", out_valid, 0);
        checkOutput("t0 res in reset", res, 0);
        checkOutput("t0 ops_done in reset", ops_done, 0);
        @(negedge clk);
        rst = 1'b1;
        #3;
        checkOutput("t0 in_ready after reset", in_ready, 1);

        // All eight ops on one operand pair, back to back.
        base = popLog.size();
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, 3'(k), 8'hF0, 8'h3C, T'(k), 1'b1, 1'b0);
        drain();
        checkOutput("t1 pop count", popLog.size() - base, 8);
        if (popLog.size() - base == 8) begin
            for (int k = 0; k < 8; k++) begin
                checkOutput("t1 res", popLog[base+k].res, exp1[k]);
                checkOutput("t1 tag", popLog[base+k].tag, k);
                checkOutput("t1 latency", popLog[base+k].popCyc - popLog[base+k].acceptCyc, 2);
            end
            checkOutput("t1 parity of 0xCC", popLog[base+2].parity, 0);
        end

        // Flag corner cases.
        base = popLog.size();
        applyStimulus(1'b1, 3'd0, 8'h0F, 8'hF0, 4'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd2, 8'h0F, 8'hF0, 4'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd1, 8'h01, 8'h00, 4'd3, 1'b1, 1'b0);
        drain();
        checkOutput("t2 pop count", popLog.size() - base, 3);
        if (popLog.size() - base == 3) begin
            checkOutput("t2 and res", popLog[base].res, 8'h00);
            checkOutput("t2 and zero", popLog[base].zero, 1);
            checkOutput("t2 and parity", popLog[base].parity, 0);
            checkOutput("t2 xor res", popLog[base+1].res, 8'hFF);
            checkOutput("t2 xor zero", popLog[base+1].zero, 0);
            checkOutput("t2 xor parity", popLog[base+1].parity, 0);
            checkOutput("t2 or res", popLog[base+2].res, 8'h01);
            checkOutput("t2 or parity", popLog[base+2].parity, 1);
        end

        // Backpressure: only STAGES ops fit, head stays frozen.
        base = popLog.size();
        a0 = acceptCount;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 3'(k), 8'hAA, 8'h0F, T'(k), 1'b0, 1'b0);
            if (k >= 2) begin
                #3;
                checkOutput("t3 stalled out_valid", out_valid, 1);
                checkOutput("t3 frozen res", res, 8'h0A);
                checkOutput("t3 stalled in_ready", in_ready, 0);
            end
        end
        #2;
        checkOutput("t3 accepted while stalled", acceptCount - a0, 2);
        for (int j = 0; j < 4; j++)
            applyStimulus(1'b1, 3'(j), 8'h55, 8'h0F, T'(8 + j), 1'b1, 1'b0);
        drain();
        checkOutput("t3 total accepted", acceptCount - a0, 6);
        checkOutput("t3 pop count", popLog.size() - base, 6);
        if (popLog.size() - base == 6) begin
            checkOutput("t3 first res", popLog[base].res, 8'h0A);
            checkOutput("t3 first tag", popLog[base].tag, 0);
            checkOutput("t3 second res", popLog[base+1].res, 8'hAF);
            checkOutput("t3 second tag", popLog[base+1].tag, 1);
            checkOutput("t3 third res", popLog[base+2].res, 8'h05);
            checkOutput("t3 third tag", popLog[base+2].tag, 8);
        end

        // Flush with two ops in flight.
        savedPops = popCount;
        savedDone = modelDone;
        applyStimulus(1'b1, 3'd1, 8'h12, 8'h34, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 8'h12, 8'h34, 4'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
        #3;
        checkOutput("t4 out_valid after flush", out_valid, 0);
        checkOutput("t4 ops_done after flush", ops_done, savedDone);
        repeat (3) applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
        #3;
        checkOutput("t4 nothing emitted", popCount - savedPops, 0);
        applyStimulus(1'b1, 3'd1, 8'hFF, 8'h00, 4'd7, 1'b1, 1'b1);
        #3;
        checkOutput("t4 in_ready during flush", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
            #3;
            checkOutput("t4 flushed input not accepted", out_valid, 0);
        end

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 3'd1, 8'h81, 8'h18, T'(k), 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t5 async out_valid", out_valid, 0);
        checkOutput("t5 async res", res, 0);
        checkOutput("t5 async ops_done", ops_done, 0);
        checkOutput("t5 async ops_done small", ops_done_b, 0);
        @(negedge clk);
        rst = 1'b1;
        base = popLog.size();
        applyStimulus(1'b1, 3'd2, 8'h5A, 8'h0F, 4'd3, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++)
            applyStimulus(1'b1, 3'(k), 8'(k * 7), 8'hC3, T'(k), 1'b1, 1'b0);
        drain();
        checkOutput("t5 pop count", popLog.size() - base, 17);
        if (popLog.size() > base) begin
            checkOutput("t5 first res after reset", popLog[base].res, 8'h55);
            checkOutput("t5 first tag after reset", popLog[base].tag, 3);
        end
        checkOutput("t6 ops_done 17", ops_done, 17);
        checkOutput("t6 ops_done wrapped", ops_done_b, 1);

        // Random handshakes against the model.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        base = popLog.size();
        a0 = acceptCount;
        guard = 0;
        while (acceptCount - a0 < 1000 && guard < 20000) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                          8'($urandom), T'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            #1;
            guard++;
        end
        if (guard >= 20000) timeoutFail("t7 random accept budget");
        drain();
        checkOutput("t7 accepted", acceptCount - a0, 1000);
        checkOutput("t7 popped", popLog.size() - base, 1000);
        checkOutput("t7 ops_done", ops_done, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
